bus_perm2: RTL and testbench



---
 rtl/bus_perm2_pkg.sv | 37 +++
 rtl/bus_perm2_swap.sv | 31 +++
 rtl/bus_perm2.sv | 106 ++++++++++
 tb/tb_bus_perm2.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/bus_perm2_pkg.sv
// ---------------------------------------------------------------------------
// bus_perm2_pkg
// Shared constants and helpers for the 8-lane bus permutator.
//   LANES        : number of lanes moved by the network
//   STAGES       : number of switch stages
//   SW_PER_STAGE : 2x2 switches per stage
//   STRIDE       : lane distance between the two inputs of a switch, per stage
//   pair_of()    : lane pair (a,b) handled by switch k of stage s
// ---------------------------------------------------------------------------
package bus_perm2_pkg;

    localparam int LANES        = 8;
    localparam int STAGES       = 4;
    localparam int SW_PER_STAGE = 4;
    localparam int CTRL_W       = STAGES * SW_PER_STAGE;

    localparam int STRIDE [STAGES] = '{1, 2, 4, 1};

    typedef struct packed {
        logic [2:0] a;
        logic [2:0] b;
    } lane_pair_t;

    // Switches are numbered in ascending order of their lower lane: within
    // each block of 2*stride lanes the first 'stride' lanes pair upward.
    function automatic lane_pair_t pair_of(input int stage, input int sw);
        int         st;
        int         lo;
        lane_pair_t p;
        st   = STRIDE[stage];
        lo   = (sw / st) * (2 * st) + (sw % st);
        p.a  = 3'(lo);
        p.b  = 3'(lo + st);
        return p;
    endfunction

endpackage

// File: rtl/bus_perm2_swap.sv
// ---------------------------------------------------------------------------
// bus_perm2_swap
// One 2x2 lane switch. Lanes are moved whole, never modified.
//   a, b  : input lanes
//   sel   : 1 = swap (y0=b, y1=a), 0 = pass (y0=a, y1=b)
//   y0,y1 : output lanes
// ---------------------------------------------------------------------------
module bus_perm2_swap #(
    parameter int LANE_W = 4
) (
    input  logic [LANE_W-1:0] a,
    input  logic [LANE_W-1:0] b,
    input  logic              sel,
    output logic [LANE_W-1:0] y0,
    output logic [LANE_W-1:0] y1
);

    // Pass or cross the two lanes.
    always_comb begin
        y0 = a;
        y1 = b;
        if (sel) begin
            y0 = b;
            y1 = a;
        end else begin
            y0 = a;
            y1 = b;
        end
    end

endmodule

// File: rtl/bus_perm2.sv
// ---------------------------------------------------------------------------
// bus_perm2
// 8-lane bus permutator: four stages of 2x2 swap switches (strides 1,2,4,1)
// steered by a 16-bit control word, followed by an output register.
// Control bit 4*s+k drives switch k of stage s.
//   clk     : rising-edge clock
//   rst_n   : asynchronous active-low reset, clears all registers
//   control : switch settings, may change every cycle
//   din     : packed lane array, din[i] is lane i
//   dout    : permuted lanes, registered
// Build option BUSPERM2_PIPE_EN: inserts a register bank after stage 1
// (lanes plus control[15:8]), raising latency from 1 to 2 cycles.
// ---------------------------------------------------------------------------
module bus_perm2
    import bus_perm2_pkg::*;
#(
    parameter int LANE_W = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [CTRL_W-1:0]             control,
    input  logic [LANES-1:0][LANE_W-1:0]  din,
    output logic [LANES-1:0][LANE_W-1:0]  dout
);

    logic [CTRL_W-1:0]            ctrl_eff_s;
    logic [LANES-1:0][LANE_W-1:0] dout_r;

`ifdef BUSPERM2_PIPE_EN
    logic [LANE_W-1:0]            mid_r [LANES];
    logic [CTRL_W/2-1:0]          ctrl_hi_r;

    // Stages 2 and 3 see the control bits captured alongside their lanes.
    assign ctrl_eff_s = {ctrl_hi_r, control[CTRL_W/2-1:0]};
`else
    assign ctrl_eff_s = control;
`endif

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        logic [LANE_W-1:0]       lin_s  [LANES];
        logic [LANE_W-1:0]       lout_s [LANES];
        logic [SW_PER_STAGE-1:0] sel_s;

        assign sel_s = ctrl_eff_s[SW_PER_STAGE*s +: SW_PER_STAGE];

        if (s == 0) begin : g_src_in
            for (genvar i = 0; i < LANES; i++) begin : g_lane
                assign lin_s[i] = din[i];
            end
`ifdef BUSPERM2_PIPE_EN
        end else if (s == 2) begin : g_src_pipe
            for (genvar i = 0; i < LANES; i++) begin : g_lane
                assign lin_s[i] = mid_r[i];
            end
`endif
        end else begin : g_src_prev
            for (genvar i = 0; i < LANES; i++) begin : g_lane
                assign lin_s[i] = g_stage[s-1].lout_s[i];
            end
        end

        for (genvar k = 0; k < SW_PER_STAGE; k++) begin : g_sw
            localparam lane_pair_t PAIR = pair_of(s, k);
            bus_perm2_swap #(
                .LANE_W (LANE_W)
            ) u_swap (
                .a   (lin_s[PAIR.a]),
                .b   (lin_s[PAIR.b]),
                .sel (sel_s[k]),
                .y0  (lout_s[PAIR.a]),
                .y1  (lout_s[PAIR.b])
            );
        end
    end

`ifdef BUSPERM2_PIPE_EN
    // Mid-network pipeline bank: stage-1 lanes and the upper control half.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LANES; i++) begin
                mid_r[i] <= '0;
            end
            ctrl_hi_r <= '0;
        end else begin
            for (int i = 0; i < LANES; i++) begin
                mid_r[i] <= g_stage[1].lout_s[i];
            end
            ctrl_hi_r <= control[CTRL_W-1:CTRL_W/2];
        end
    end
`endif

    // Output register capturing the last stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_r <= '0;
        end else begin
            for (int i = 0; i < LANES; i++) begin
                dout_r[i] <= g_stage[STAGES-1].lout_s[i];
            end
        end
    end

    assign dout = dout_r;

endmodule

// File: tb/tb_bus_perm2.sv
// ---------------------------------------------------------------------------
// tb_bus_perm2
// Scoreboard bench for bus_perm2: the stimulus process pushes the hand-derived
// expected lanes when it drives a vector; the monitor tracks the issue flag
// through the design latency and pops/compares when the output is due.
// ---------------------------------------------------------------------------
module tb_bus_perm2;

    localparam int LANE_W = 4;
`ifdef BUSPERM2_PIPE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    typedef logic [7:0][LANE_W-1:0] vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] control;
    vec_t        din;
    vec_t        dout;
    logic        issue;
    vec_t        exp_q [$];
    vec_t        zero_v;
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    bus_perm2 #(
        .LANE_W (LANE_W)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .control (control),
        .din     (din),
        .dout    (dout)
    );

    function automatic vec_t lanes(input int l0, input int l1, input int l2, input int l3,
                                   input int l4, input int l5, input int l6, input int l7);
        return {4'(l7), 4'(l6), 4'(l5), 4'(l4), 4'(l3), 4'(l2), 4'(l1), 4'(l0)};
    endfunction

    task automatic check(input string name, input vec_t act, input vec_t expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: dout=%h expected=%h", name, act, expv);
        end
    endtask

    task automatic apply(input logic [15:0] ctrl, input vec_t data, input vec_t expv);
        @(negedge clk);
        control = ctrl;
        din     = data;
        issue   = 1'b1;
        exp_q.push_back(expv);
    endtask

    task automatic drain();
        @(negedge clk);
        issue = 1'b0;
        for (int n = 0; n < 20 && exp_q.size() != 0; n++) @(negedge clk);
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: pending=%0d required=0", exp_q.size());
            exp_q.delete();
        end
    endtask

    // Monitor: delay the issue flag by the design latency, then compare.
    initial begin
        logic [1:0] v;
        v = 2'b00;
        forever begin
            @(posedge clk);
            if (!rst_n) v = 2'b00;
            else        v = {v[0], issue};
            #1;
            if (rst_n && v[LAT-1]) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: dout=%h required=no output", dout);
                end else begin
                    check("scoreboard", dout, exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        vec_t ramp;
        vec_t rev;
        zero_v  = '0;
        ramp    = lanes(0, 1, 2, 3, 4, 5, 6, 7);
        rev     = lanes(15, 14, 13, 12, 11, 10, 9, 8);
        control = 16'h0000;
        din     = ramp;
        issue   = 1'b0;

        repeat (3) @(negedge clk);
        check("reset_hold", dout, zero_v);
        @(negedge clk);
        rst_n = 1'b1;

        // Back-to-back vectors; control changes every cycle.
        apply(16'h0000, ramp, lanes(0, 1, 2, 3, 4, 5, 6, 7));
        apply(16'h0001, ramp, lanes(1, 0, 2, 3, 4, 5, 6, 7));
        apply(16'hFFFF, ramp, lanes(6, 7, 4, 5, 2, 3, 0, 1));
        apply(16'h0F00, ramp, lanes(4, 5, 6, 7, 0, 1, 2, 3));
        apply(16'h00F0, ramp, lanes(2, 3, 0, 1, 6, 7, 4, 5));
        apply(16'h0011, ramp, lanes(2, 0, 1, 3, 4, 5, 6, 7));
        apply(16'hF000, ramp, lanes(1, 0, 3, 2, 5, 4, 7, 6));
        apply(16'h0010, ramp, lanes(2, 1, 0, 3, 4, 5, 6, 7));
        apply(16'h0020, ramp, lanes(0, 3, 2, 1, 4, 5, 6, 7));
        apply(16'h0400, ramp, lanes(0, 1, 6, 3, 4, 5, 2, 7));
        apply(16'h1000, ramp, lanes(1, 0, 2, 3, 4, 5, 6, 7));
        apply(16'hFFFF, rev,  lanes(9, 8, 11, 10, 13, 12, 15, 14));
        apply(16'h0000, ramp, lanes(0, 1, 2, 3, 4, 5, 6, 7));
        drain();

        // Load a non-zero output, then reset between clock edges.
        apply(16'h0F00, ramp, lanes(4, 5, 6, 7, 0, 1, 2, 3));
        drain();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_immediate", dout, zero_v);
        exp_q.delete();
        @(posedge clk);
        #1;
        check("reset_held_after_edge", dout, zero_v);
        @(negedge clk);
        rst_n = 1'b1;

        apply(16'h00F0, ramp, lanes(2, 3, 0, 1, 6, 7, 4, 5));
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
